// File: rtl/alu_cmd_driver.sv
// Request/response front end that sequences a combinational WIDTH-bit ALU.
// Optional ALU_STATS_EN adds saturating response counters stat_ops/stat_neg.
module alu_cmd_driver #(
  parameter int         WIDTH  = 4,
  parameter int         SETTLE = 1,
  parameter logic [1:0] OFF    = 2'd0,
  parameter logic [1:0] ADD    = 2'd1,
  parameter logic [1:0] SUB    = 2'd2,
  parameter logic [1:0] NO_OP  = 2'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_data,
  output logic [1:0]       rsp_op
`ifdef ALU_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_neg
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH:0]   data_reg, data_next;
  logic [WIDTH:0]   last_reg, last_next;
  logic             neg_reg, neg_next;
  logic [WIDTH:0]   out_ext;
  logic [WIDTH:0]   conv;

  // SUB returns a magnitude; flag marks a negative difference.
  assign out_ext = {1'b0, alu_out};
  assign conv    = (op_reg == ADD) ? {alu_flag, alu_out}
                 : (alu_flag ? (~out_ext + 1'b1) : out_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OFF;
      a_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
      last_reg  <= '0;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      neg_reg   <= neg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    neg_next   = neg_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OFF;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_next = req_op;
          a_next  = req_a;
          b_next  = req_b;
          if (req_op == ADD || req_op == SUB) begin
            state_next = DRIVE;
            cnt_next   = 4'(SETTLE);
          end else begin
            // OFF and NO_OP never touch the ALU.
            state_next = RESP;
            data_next  = (req_op == NO_OP) ? last_reg : '0;
            neg_next   = 1'b0;
          end
        end
      end
      DRIVE: begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = op_reg;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          data_next  = conv;
          last_next  = conv;
          neg_next   = (op_reg == SUB) && alu_flag;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_data = data_reg;
  assign rsp_op   = op_reg;

`ifdef ALU_STATS_EN
  logic [15:0] ops_cnt_reg;
  logic [15:0] neg_cnt_reg;
  logic        rsp_hs;

  assign rsp_hs = (state_reg == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt_reg <= '0;
      neg_cnt_reg <= '0;
    end else begin
      if (rsp_hs && ops_cnt_reg != 16'hFFFF) ops_cnt_reg <= ops_cnt_reg + 16'd1;
      if (rsp_hs && neg_reg && neg_cnt_reg != 16'hFFFF) neg_cnt_reg <= neg_cnt_reg + 16'd1;
    end
  end

  assign stat_ops = ops_cnt_reg;
  assign stat_neg = neg_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: instance 0 uses SETTLE=1, instance 1 SETTLE=4.
// Each instance is wired to a behavioural ALU; ALU_STATS_EN enables the counter test.
module tb_alu_cmd_driver;

  localparam logic [1:0] OFF = 2'd0, ADD = 2'd1, SUB = 2'd2, NO_OP = 2'd3;

  logic       clk = 1'b0;
  logic       rst       [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic [1:0] req_op    [2];
  logic [3:0] req_a     [2];
  logic [3:0] req_b     [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [1:0] alu_op    [2];
  logic [3:0] alu_out   [2];
  logic       alu_flag  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [4:0] rsp_data  [2];
  logic [1:0] rsp_op    [2];
`ifdef ALU_STATS_EN
  logic [15:0] stat_ops [2];
  logic [15:0] stat_neg [2];
`endif

  int checks = 0;
  int errors = 0;
  int noop_seen = 0;

  always #5 clk = ~clk;

  // Reference ALU: NO_OP would latch, so it returns 0 and alu_op==3 is flagged separately.
  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      ADD: r = {1'b0, a} + {1'b0, b};
      SUB: r = (b > a) ? {1'b1, 4'(b - a)} : {1'b0, 4'(a - b)};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      assign {alu_flag[gi], alu_out[gi]} = alu_fn(alu_op[gi], alu_a[gi], alu_b[gi]);

      alu_cmd_driver #(.WIDTH(4), .SETTLE(gi == 0 ? 1 : 4)) dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_op    (req_op[gi]),
        .req_a     (req_a[gi]),
        .req_b     (req_b[gi]),
        .alu_a     (alu_a[gi]),
        .alu_b     (alu_b[gi]),
        .alu_op    (alu_op[gi]),
        .alu_out   (alu_out[gi]),
        .alu_flag  (alu_flag[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_data  (rsp_data[gi]),
        .rsp_op    (rsp_op[gi])
`ifdef ALU_STATS_EN
        ,
        .stat_ops  (stat_ops[gi]),
        .stat_neg  (stat_neg[gi])
`endif
      );

      always @(negedge clk) if (alu_op[gi] == NO_OP) noop_seen++;
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[k] = 1'b0;
  endtask

  // Present one request, measure edges from acceptance to rsp_valid, check result, optionally handshake.
  task automatic do_req(input int k, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_data, input bit hs);
    int lat;
    int exp_lat;
    exp_lat = (op == ADD || op == SUB) ? (k == 0 ? 1 : 4) : 0;
    check("req_ready_idle", req_ready[k], 1);
    req_valid[k] = 1'b1; req_op[k] = op; req_a[k] = a; req_b[k] = b;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    if (op == ADD || op == SUB) begin
      check("drive_alu_op", alu_op[k], op);
      check("drive_alu_a", alu_a[k], a);
      check("drive_alu_b", alu_b[k], b);
      check("drive_req_ready", req_ready[k], 0);
    end
    lat = 0;
    while (!rsp_valid[k] && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_data", rsp_data[k], exp_data);
    check("rsp_op", rsp_op[k], op);
    $display("txn dut%0d op=%0d a=%0d b=%0d data=%0d lat=%0d", k, op, a, b, rsp_data[k], lat);
    if (hs) begin
      rsp_ready[k] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[k] = 1'b0;
      check("post_hs_valid", rsp_valid[k], 0);
      check("post_hs_ready", req_ready[k], 1);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_op[k] = OFF;
      req_a[k] = '0; req_b[k] = '0; rsp_ready[k] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    check("rst_req_ready", req_ready[0], 1);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_rsp_data", rsp_data[0], 0);
    check("rst_rsp_op", rsp_op[0], OFF);
    check("rst_alu_op", alu_op[0], OFF);
    check("rst_alu_a", alu_a[0], 0);
    check("rst_alu_b", alu_b[0], 0);

    do_req(0, ADD, 4'd9, 4'd8, 5'b10001, 1);
    do_req(0, SUB, 4'd3, 4'd5, 5'b11110, 1);
    do_req(0, SUB, 4'd7, 4'd2, 5'b00101, 1);
    do_req(0, NO_OP, 4'd0, 4'd0, 5'b00101, 1);
    do_req(0, OFF, 4'd6, 4'd6, 5'b00000, 1);

    // Backpressure: response held for 10 cycles, stray request ignored.
    do_req(0, ADD, 4'd15, 4'd15, 5'b11110, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        req_valid[0] = 1'b1; req_op[0] = SUB; req_a[0] = 4'd1; req_b[0] = 4'd2;
      end else begin
        req_valid[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      check("stall_valid", rsp_valid[0], 1);
      check("stall_data", rsp_data[0], 5'b11110);
      check("stall_op", rsp_op[0], ADD);
      check("stall_req_ready", req_ready[0], 0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    check("stall_release_valid", rsp_valid[0], 0);
    @(posedge clk);
    #1;
    check("stray_not_taken", rsp_valid[0], 0);
    check("stray_ready", req_ready[0], 1);
    do_req(0, NO_OP, 4'd0, 4'd0, 5'b11110, 1);

    // SETTLE=4: full ADD, then reset mid-DRIVE clears the last result.
    do_req(1, ADD, 4'd2, 4'd3, 5'd5, 1);
    req_valid[1] = 1'b1; req_op[1] = ADD; req_a[1] = 4'd6; req_b[1] = 4'd1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 check("mid_drive_op", alu_op[1], ADD);
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    check("mid_rst_valid", rsp_valid[1], 0);
    check("mid_rst_alu_op", alu_op[1], OFF);
    check("mid_rst_ready", req_ready[1], 1);
    repeat (6) @(posedge clk);
    #1 check("mid_rst_no_rsp", rsp_valid[1], 0);
    do_req(1, NO_OP, 4'd0, 4'd0, 5'd0, 1);

`ifdef ALU_STATS_EN
    do_reset(0);
    check("stat_ops_rst", stat_ops[0], 0);
    check("stat_neg_rst", stat_neg[0], 0);
    do_req(0, ADD, 4'd1, 4'd1, 5'd2, 1);
    do_req(0, ADD, 4'd8, 4'd8, 5'd16, 1);
    do_req(0, ADD, 4'd15, 4'd1, 5'd16, 1);
    do_req(0, SUB, 4'd1, 4'd3, 5'b11110, 1);
    do_req(0, SUB, 4'd0, 4'd15, 5'b10001, 1);
    do_req(0, SUB, 4'd9, 4'd4, 5'd5, 1);
    check("stat_ops", stat_ops[0], 6);
    check("stat_neg", stat_neg[0], 2);
`endif

    check("alu_op_noop_seen", noop_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
